// File: rtl/instr_fetch_pkg.sv
// riscv_definitions: fetch FSM states, NOP constant, data bus union and alignment helper
package riscv_definitions;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} fetchState_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef union packed {
    logic [31:0] word;
    logic [3:0][7:0] bytes;
  } dataBus_u;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction
endpackage

// File: rtl/instr_fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {pc,instr} holding slot (clk,rst,flush,load,unload,load_pc,load_instr -> valid,pc,instr), built only with FETCH_SKID_EN
`ifdef FETCH_SKID_EN
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        unload,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  always_ff @(posedge clk)
    valid <= (rst || flush) ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : valid;
  always_ff @(posedge clk)
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
endmodule
`endif

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, one-outstanding imem requests, redirect/squash and IF/ID register (imem_* bus, branch_taken/jump_addr/stall in, if_valid/if_pc/if_instr out; FETCH_SKID_EN adds a stall skid buffer)
module instr_fetch
  import riscv_definitions::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  dataBus_u    jump_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output dataBus_u    if_pc,
  output logic [31:0] if_instr
);
  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d, out_pc_q, out_pc_d, target;
  logic redir, accept, issue_ok, deliver, stall_rsp, replay;
  logic skid_valid;
  logic [31:0] skid_pc, skid_instr;
  logic        nxt_valid;
  logic [31:0] nxt_pc, nxt_instr;
  assign target    = word_align(jump_addr.word);
  assign redir     = branch_taken && !stall;
  assign imem_addr = redir ? target : pc_q;
  assign issue_ok  = !rst && !stall && !skid_valid;
  assign imem_req  = issue_ok && (state_q == FETCH || imem_rvalid);
  assign accept    = imem_req && imem_ready;
  assign stall_rsp = state_q == WAIT && imem_rvalid && stall;
  assign deliver   = state_q == WAIT && imem_rvalid && !stall && !redir;
`ifdef FETCH_SKID_EN
  assign replay = 1'b0;
  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (redir),
    .load       (stall_rsp),
    .unload     (skid_valid && !stall),
    .load_pc    (out_pc_q),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );
`else
  assign replay     = stall_rsp;
  assign skid_valid = 1'b0;
  assign skid_pc    = 32'h0;
  assign skid_instr = NOP_INSTR;
`endif
  always_comb begin
    state_d   = (state_q == FETCH || imem_rvalid) ? (accept ? WAIT : FETCH)
              : (state_q == WAIT && redir) ? DROP : state_q;
    pc_d      = accept ? imem_addr + 32'd4 : redir ? target : replay ? out_pc_q : pc_q;
    out_pc_d  = accept ? imem_addr : out_pc_q;
    nxt_valid = !redir && (skid_valid || deliver);
    nxt_pc    = redir ? 32'h0 : skid_valid ? skid_pc : deliver ? out_pc_q : 32'h0;
    nxt_instr = redir ? NOP_INSTR : skid_valid ? skid_instr : deliver ? imem_rdata : NOP_INSTR;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      out_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
    end
  always_ff @(posedge clk)
    if (rst) begin
      if_valid   <= 1'b0;
      if_pc.word <= 32'h0;
      if_instr   <= NOP_INSTR;
    end else if (!stall) begin
      if_valid   <= nxt_valid;
      if_pc.word <= nxt_pc;
      if_instr   <= nxt_instr;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with RESET_PC=0x100
module tb_instr_fetch;
  logic clk = 1'b0, rst = 1'b1, branch_taken = 1'b0, stall = 1'b0;
  logic imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] jump_addr = 32'h0, imem_rdata = 32'h0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(32'h100)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .jump_addr    (jump_addr),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h1300_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic bt, input logic [31:0] ja, input logic st, input logic rdy,
                     input logic rv, input logic [31:0] rd);
    branch_taken = bt;
    jump_addr    = ja;
    stall        = st;
    imem_ready   = rdy;
    imem_rvalid  = rv;
    imem_rdata   = rd;
    #1;
  endtask
  task automatic req(input string tag, input logic r, input logic [31:0] a);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, r});
    if (r) chk({tag, "_addr"}, imem_addr, a);
  endtask
  task automatic ifid(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_instr"}, if_instr, ins(pc));
    end
  endtask
  initial begin
    drv(0, 0, 0, 1, 0, 0);
    tick;
    tick;
    req("rst_hold", 0, 0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    rst = 1'b0;
    drv(0, 0, 0, 1, 0, 0);
    req("c0", 1, 32'h100);
    ifid("c0", 0, 0);
    tick;
    drv(0, 0, 0, 1, 1, ins(32'h100));
    req("c1", 1, 32'h104);
    ifid("c1", 0, 0);
    tick;
    drv(0, 0, 0, 1, 1, ins(32'h104));
    req("c2", 1, 32'h108);
    ifid("c2", 1, 32'h100);
    tick;
    drv(0, 0, 0, 1, 1, ins(32'h108));
    req("c3", 1, 32'h10C);
    ifid("c3", 1, 32'h104);
    tick;
    drv(1, 32'h3000, 1, 1, 1, ins(32'h10C));
    req("stall_rsp", 0, 0);
    ifid("c4", 1, 32'h108);
    tick;
    drv(1, 32'h3000, 1, 1, 0, 0);
    req("stall_br", 0, 0);
    ifid("stall_hold1", 1, 32'h108);
    tick;
    drv(0, 0, 1, 1, 0, 0);
    req("stall3", 0, 0);
    ifid("stall_hold2", 1, 32'h108);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("stall_hold3", 1, 32'h108);
`ifdef FETCH_SKID_EN
    req("skid_full", 0, 0);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("skid_out", 1, 32'h10C);
    req("after_skid", 1, 32'h110);
    tick;
    drv(1, 32'h2002, 0, 1, 0, 0);
    ifid("c9", 0, 0);
`else
    req("replay", 1, 32'h10C);
    tick;
    drv(0, 0, 0, 1, 1, ins(32'h10C));
    ifid("replay_gap", 0, 0);
    req("c8", 1, 32'h110);
    tick;
    drv(1, 32'h2002, 0, 1, 0, 0);
    ifid("replay_out", 1, 32'h10C);
`endif
    req("redir_wait", 0, 0);
    tick;
    drv(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    ifid("redir_bubble", 0, 0);
    req("drop_issue", 1, 32'h2000);
    tick;
    drv(0, 0, 0, 0, 1, ins(32'h2000));
    ifid("drop_bubble", 0, 0);
    chk("no_wrong_path", {31'b0, if_instr !== 32'hDEAD_BEEF}, 32'h1);
    req("c11", 1, 32'h2004);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    ifid("target_out", 1, 32'h2000);
    req("unaccepted", 1, 32'h2004);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("c13", 0, 0);
    req("c13", 1, 32'h2004);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    req("k3_a", 0, 0);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    req("k3_b", 0, 0);
    ifid("k3_b", 0, 0);
    tick;
    drv(0, 0, 0, 0, 1, ins(32'h2004));
    req("k3_c", 1, 32'h2008);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("k3_out", 1, 32'h2004);
    req("c17", 1, 32'h2008);
    tick;
    drv(1, 32'h3007, 0, 1, 1, 32'hBAD0_BAD0);
    ifid("c18", 0, 0);
    req("redir_rvalid", 1, 32'h3004);
    tick;
    drv(0, 0, 0, 0, 1, ins(32'h3004));
    ifid("redir_rv_bubble", 0, 0);
    chk("no_wrong_path2", {31'b0, if_instr !== 32'hBAD0_BAD0}, 32'h1);
    req("c19", 1, 32'h3008);
    tick;
    drv(1, 32'hFFFF_FFFC, 0, 1, 0, 0);
    ifid("redir_t2", 1, 32'h3004);
    req("wrap_issue", 1, 32'hFFFF_FFFC);
    tick;
    drv(0, 0, 0, 0, 1, ins(32'hFFFF_FFFC));
    ifid("c21", 0, 0);
    req("wrap_next", 1, 32'h0);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("wrap_out", 1, 32'hFFFF_FFFC);
    req("c22", 1, 32'h0);
    tick;
    rst = 1'b1;
    drv(0, 0, 0, 1, 0, 0);
    req("mid_rst", 0, 0);
    tick;
    rst = 1'b0;
    drv(0, 0, 0, 0, 1, 32'h0BAD_F00D);
    ifid("rst2", 0, 0);
    chk("rst2_pc", if_pc, 32'h0);
    req("restart", 1, 32'h100);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("stale_ignored", 0, 0);
    req("restart2", 1, 32'h100);
    tick;
    drv(0, 0, 0, 1, 1, ins(32'h100));
    ifid("c26", 0, 0);
    req("c26", 1, 32'h104);
    tick;
    drv(0, 0, 0, 1, 0, 0);
    ifid("restart_out", 1, 32'h100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
